access_sequencer: RTL and testbench

//  Sequences a credential attempt for the lock system. Packs 8 keypad digits
//  (4 username, 4 password), requests a compare from the credential checker
//  and tracks failed attempts. Enforces a timed lockout after MAX_FAILS

---
 rtl/access_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_access_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_sequencer.sv
// -----------------------------------------------------------------------------
// access_sequencer
//   Sequences one credential attempt for the lock: collects 8 keypad digits
//   (4 username, 4 password), asks the credential checker for a compare,
//   counts rejected attempts, enforces a timed lockout after MAX_FAILS
//   rejections and re-locks automatically after an idle period once unlocked.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   tick_en       1-cycle timebase strobe driving both timers
//   digit_valid   1-cycle strobe qualifying digit
//   digit         keypad value
//   clear         abort the entry in progress
//   lock_req      user re-lock request while unlocked
//   check_done    checker response strobe, check_ok qualifies it
//   check_req     compare request, held for the whole CHECK state
//   user_code     packed username, first digit in [15:12]
//   pass_code     packed password, first digit in [15:12]
//   input_count   digits accepted in this attempt (0..8)
//   locked        low only while UNLOCKED
//   lockout       high while in LOCKOUT
//   fail_pulse    1-cycle strobe per rejected attempt
//   fail_count    rejections since last success or lockout expiry
//   timer         remaining ticks in LOCKOUT/UNLOCKED, else 0
// -----------------------------------------------------------------------------
module access_sequencer #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_TICKS  = 30,
    parameter int AUTOLOCK_TICKS = 15,
    parameter int TIMER_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_en,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    input  logic               clear,
    input  logic               lock_req,
    input  logic               check_done,
    input  logic               check_ok,
    output logic               check_req,
    output logic [15:0]        user_code,
    output logic [15:0]        pass_code,
    output logic [3:0]         input_count,
    output logic               locked,
    output logic               lockout,
    output logic               fail_pulse,
    output logic [1:0]         fail_count,
    output logic [TIMER_W-1:0] timer
);

    localparam logic [1:0] ST_ENTRY    = 2'd0;
    localparam logic [1:0] ST_CHECK    = 2'd1;
    localparam logic [1:0] ST_UNLOCKED = 2'd2;
    localparam logic [1:0] ST_LOCKOUT  = 2'd3;

    localparam logic [TIMER_W-1:0] AUTO_LOAD  = TIMER_W'(AUTOLOCK_TICKS);
    localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [1:0]         FAIL_LIMIT = 2'(MAX_FAILS);

    logic [1:0]         state, state_n;
    logic [15:0]        user_n, pass_n;
    logic [3:0]         count_n;
    logic [1:0]         fails_n;
    logic [1:0]         fails_inc;
    logic [TIMER_W-1:0] timer_n;
    logic               fail_n;
    logic               timer_last;

    assign fails_inc  = fail_count + 2'd1;
    // The tick seen at timer==1 is the one that expires the timer; <= also
    // keeps a zero-loaded timer from wrapping.
    assign timer_last = (timer <= TIMER_ONE);

    always_comb begin
        state_n = state;
        user_n  = user_code;
        pass_n  = pass_code;
        count_n = input_count;
        fails_n = fail_count;
        timer_n = timer;
        fail_n  = 1'b0;

        case (state)
            ST_ENTRY: begin
                timer_n = '0;
                if (clear) begin
                    // clear outranks a simultaneous digit, which is dropped
                    user_n  = '0;
                    pass_n  = '0;
                    count_n = '0;
                end else if (digit_valid) begin
                    if (input_count < 4'd4)
                        user_n = {user_code[11:0], digit};
                    else
                        pass_n = {pass_code[11:0], digit};
                    count_n = input_count + 4'd1;
                    if (input_count == 4'd7)
                        state_n = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (check_done) begin
                    user_n  = '0;
                    pass_n  = '0;
                    count_n = '0;
                    if (check_ok) begin
                        state_n = ST_UNLOCKED;
                        fails_n = '0;
                        timer_n = AUTO_LOAD;
                    end else begin
                        fail_n  = 1'b1;
                        fails_n = fails_inc;
                        if (fails_inc == FAIL_LIMIT) begin
                            state_n = ST_LOCKOUT;
                            timer_n = LOCK_LOAD;
                        end else begin
                            state_n = ST_ENTRY;
                        end
                    end
                end
            end

            ST_UNLOCKED: begin
                if (lock_req) begin
                    state_n = ST_ENTRY;
                    timer_n = '0;
                end else if (digit_valid) begin
                    // keypad activity counts as "not idle"; digit not stored
                    timer_n = AUTO_LOAD;
                end else if (tick_en) begin
                    if (timer_last) begin
                        state_n = ST_ENTRY;
                        timer_n = '0;
                    end else begin
                        timer_n = timer - TIMER_ONE;
                    end
                end
            end

            ST_LOCKOUT: begin
                count_n = '0;
                if (tick_en) begin
                    if (timer_last) begin
                        state_n = ST_ENTRY;
                        timer_n = '0;
                        fails_n = '0;
                    end else begin
                        timer_n = timer - TIMER_ONE;
                    end
                end
            end

            default: begin
                state_n = ST_ENTRY;
                user_n  = '0;
                pass_n  = '0;
                count_n = '0;
                timer_n = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // the state register rather than lagging it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ENTRY;
            check_req   <= 1'b0;
            user_code   <= '0;
            pass_code   <= '0;
            input_count <= '0;
            locked      <= 1'b1;
            lockout     <= 1'b0;
            fail_pulse  <= 1'b0;
            fail_count  <= '0;
            timer       <= '0;
        end else begin
            state       <= state_n;
            check_req   <= (state_n == ST_CHECK);
            user_code   <= user_n;
            pass_code   <= pass_n;
            input_count <= count_n;
            locked      <= (state_n != ST_UNLOCKED);
            lockout     <= (state_n == ST_LOCKOUT);
            fail_pulse  <= fail_n;
            fail_count  <= fails_n;
            timer       <= timer_n;
        end
    end

endmodule

// File: tb/tb_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_access_sequencer
//   Directed bench for access_sequencer. A queue-based model of the attempt
//   is compared against every DUT output on each falling clock edge; literal
//   expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_access_sequencer;

    localparam int MAXF  = 3;
    localparam int LOCKT = 30;
    localparam int AUTOT = 15;
    localparam int TW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          tick_en = 1'b0;
    logic          digit_valid = 1'b0;
    logic [3:0]    digit = '0;
    logic          clear = 1'b0;
    logic          lock_req = 1'b0;
    logic          check_done = 1'b0;
    logic          check_ok = 1'b0;
    logic          check_req;
    logic [15:0]   user_code, pass_code;
    logic [3:0]    input_count;
    logic          locked, lockout, fail_pulse;
    logic [1:0]    fail_count;
    logic [TW-1:0] timer;

    access_sequencer #(
        .MAX_FAILS(MAXF), .LOCKOUT_TICKS(LOCKT),
        .AUTOLOCK_TICKS(AUTOT), .TIMER_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
        .digit_valid(digit_valid), .digit(digit), .clear(clear),
        .lock_req(lock_req), .check_done(check_done), .check_ok(check_ok),
        .check_req(check_req), .user_code(user_code), .pass_code(pass_code),
        .input_count(input_count), .locked(locked), .lockout(lockout),
        .fail_pulse(fail_pulse), .fail_count(fail_count), .timer(timer)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Modes by name: 0 entering, 1 awaiting checker, 2 open, 3 locked out.
    int m_mode;
    int m_digits[$];
    int m_fails;
    int m_timer;
    bit m_fp;

    function automatic int pack(input int first);
        int v = 0;
        for (int i = first; i < first + 4 && i < m_digits.size(); i++)
            v = (v << 4) | m_digits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_digits.delete();
        m_fails = 0;
        m_timer = 0;
        m_fp = 0;
    endtask

    task automatic model_step();
        m_fp = 0;
        case (m_mode)
            0: begin
                if (clear) m_digits.delete();
                else if (digit_valid) begin
                    m_digits.push_back(int'(digit));
                    if (m_digits.size() == 8) m_mode = 1;
                end
            end
            1: if (check_done) begin
                m_digits.delete();
                if (check_ok) begin
                    m_mode = 2; m_fails = 0; m_timer = AUTOT;
                end else begin
                    m_fp = 1;
                    m_fails++;
                    if (m_fails == MAXF) begin m_mode = 3; m_timer = LOCKT; end
                    else m_mode = 0;
                end
            end
            2: begin
                if (lock_req) begin m_mode = 0; m_timer = 0; end
                else if (digit_valid) m_timer = AUTOT;
                else if (tick_en) begin
                    m_timer--;
                    if (m_timer == 0) m_mode = 0;
                end
            end
            default: if (tick_en) begin
                m_timer--;
                if (m_timer == 0) begin m_mode = 0; m_fails = 0; end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("check_req",   32'(check_req),   32'(m_mode == 1));
        chk("user_code",   32'(user_code),   32'(pack(0)));
        chk("pass_code",   32'(pass_code),   32'(pack(4)));
        chk("input_count", 32'(input_count), 32'(m_digits.size()));
        chk("locked",      32'(locked),      32'(m_mode != 2));
        chk("lockout",     32'(lockout),     32'(m_mode == 3));
        chk("fail_pulse",  32'(fail_pulse),  32'(m_fp));
        chk("fail_count",  32'(fail_count),  32'(m_fails));
        chk("timer",       32'(timer),       32'(m_timer));
    endtask

    // Inputs only change just after a rising edge, so the values seen here
    // are exactly what the DUT samples on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        compare_all();
        if (rst_n) model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1; digit = d;
        cyc(1);
        digit_valid = 1'b0;
    endtask

    task automatic enter(input logic [31:0] code);
        for (int i = 7; i >= 0; i--) send_digit(code[i*4 +: 4]);
    endtask

    task automatic respond(input logic ok);
        check_done = 1'b1; check_ok = ok;
        cyc(1);
        check_done = 1'b0; check_ok = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_en = 1'b1;
        cyc(n);
        tick_en = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_locked", 32'(locked), 32'd1);
        chk("rst_count",  32'(input_count), 32'd0);
        chk("rst_req",    32'(check_req), 32'd0);

        // Basic entry
        enter(32'h0011_0011);
        chk("entry_user",  32'(user_code), 32'h0011);
        chk("entry_pass",  32'(pass_code), 32'h0011);
        chk("entry_count", 32'(input_count), 32'd8);
        chk("entry_req",   32'(check_req), 32'd1);

        // clear while waiting on the checker is ignored
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("check_clear_ign", 32'(input_count), 32'd8);

        // First rejection
        respond(1'b0);
        chk("bad_pulse", 32'(fail_pulse), 32'd1);
        chk("bad_fails", 32'(fail_count), 32'd1);
        chk("bad_count", 32'(input_count), 32'd0);
        chk("bad_req",   32'(check_req), 32'd0);
        cyc(1);
        chk("bad_pulse_end", 32'(fail_pulse), 32'd0);

        // check_done outside CHECK does nothing
        respond(1'b1);
        chk("stray_done", 32'(locked), 32'd1);

        // clear + digit collide: digit dropped
        send_digit(4'h5); send_digit(4'h6); send_digit(4'h7);
        chk("partial_user", 32'(user_code), 32'h0567);
        clear = 1'b1; digit_valid = 1'b1; digit = 4'h8;
        cyc(1);
        clear = 1'b0; digit_valid = 1'b0;
        chk("clr_count", 32'(input_count), 32'd0);
        chk("clr_user",  32'(user_code), 32'h0000);
        send_digit(4'h9);
        chk("after_clr_user", 32'(user_code), 32'h0009);
        clear = 1'b1; cyc(1); clear = 1'b0;

        // Two more rejections -> lockout
        enter(32'h1234_5678);
        chk("pass_pack", 32'(pass_code), 32'h5678);
        respond(1'b0);
        chk("fails_2", 32'(fail_count), 32'd2);
        enter(32'h1234_5678);
        respond(1'b0);
        chk("lo_flag",  32'(lockout), 32'd1);
        chk("lo_timer", 32'(timer), 32'd30);
        send_digit(4'h3);
        chk("lo_digit", 32'(input_count), 32'd0);
        lock_req = 1'b1; clear = 1'b1; cyc(1); lock_req = 1'b0; clear = 1'b0;
        ticks(29);
        chk("lo_t1",   32'(timer), 32'd1);
        chk("lo_hold", 32'(lockout), 32'd1);
        ticks(1);
        chk("lo_exit",       32'(lockout), 32'd0);
        chk("lo_exit_fails", 32'(fail_count), 32'd0);
        chk("lo_exit_lock",  32'(locked), 32'd1);

        // Unlock and auto re-lock
        enter(32'h4321_8765);
        respond(1'b1);
        chk("ul_locked", 32'(locked), 32'd0);
        chk("ul_timer",  32'(timer), 32'd15);
        ticks(12);
        chk("ul_t3", 32'(timer), 32'd3);
        send_digit(4'h2);
        chk("ul_reload", 32'(timer), 32'd15);
        chk("ul_nostore", 32'(input_count), 32'd0);
        ticks(14);
        chk("ul_t1",   32'(timer), 32'd1);
        chk("ul_open", 32'(locked), 32'd0);
        ticks(1);
        chk("auto_lock",  32'(locked), 32'd1);
        chk("auto_timer", 32'(timer), 32'd0);

        // lock_req and tick together
        enter(32'h4321_8765);
        respond(1'b1);
        ticks(4);
        lock_req = 1'b1; tick_en = 1'b1;
        cyc(1);
        lock_req = 1'b0; tick_en = 1'b0;
        chk("lr_locked", 32'(locked), 32'd1);
        chk("lr_timer",  32'(timer), 32'd0);

        // Reset in the middle of CHECK
        enter(32'h0000_0001);
        chk("pre_rst_req", 32'(check_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",    32'(check_req), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd1);
        chk("mid_rst_count",  32'(input_count), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_state", 32'(check_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
